key_event_controller: RTL and testbench
=======================================

KEY_EVENT_CONTROLLER -- requirements
Module: key_event_controller

Interface
REQ-001 Parameter FIFO_DEPTH, 4, event FIFO depth; power of two, >= 2.
REQ-002 Parameter TIMEOUT_CYCLES, 100000, clk cycles allowed between prefix byte and completing byte.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 frame  input  11  PS/2 frame from receiver: [0] start, [8:1] data LSB-first, [9] odd parity, [10] stop.
REQ-006 frame_valid  input  1  one-clk pulse, frame valid this cycle.
REQ-007 rd_en  input  1  host pop request for head event.
REQ-008 err_clear  input  1  clears sticky error flags.
REQ-009 ev_valid  output  1  FIFO non-empty, head event presented.
REQ-010 ev_code  output  8  head event scan code.
REQ-011 ev_release  output  1  head event is key release.
REQ-012 ev_extended  output  1  head event is E0-extended.
REQ-013 fifo_count  output  log2(FIFO_DEPTH)+1  entries held.
REQ-014 fifo_full  output  1  fifo_count == FIFO_DEPTH.
REQ-015 overflow  output  1  sticky: event dropped due to full FIFO.
REQ-016 frame_error  output  1  sticky: bad start/stop/parity frame or 0x00/0xFF overrun byte seen.
REQ-017 rx_reset  output  1  one-clk pulse requesting receiver resynchronisation.

Function
REQ-018 Frame valid iff frame[0]=0, frame[10]=1, XOR(frame[9:1])=1; data byte = frame[8:1].
REQ-019 FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0; decisions taken only in cycles with frame_valid=1 and frame valid.
REQ-020 IDLE: E0->GOT_E0; F0->GOT_F0; other byte -> push {ext=0,rel=0,code}, stay IDLE.
REQ-021 GOT_E0: F0->GOT_E0F0; E0->stay; other -> push {ext=1,rel=0}, ->IDLE.
REQ-022 GOT_F0: E0->GOT_E0F0; F0->stay; other -> push {ext=0,rel=1}, ->IDLE.
REQ-023 GOT_E0F0: E0/F0->stay; other -> push {ext=1,rel=1}, ->IDLE.
REQ-024 Byte 0x00 or 0xFF in any state: no push, set frame_error, ->IDLE.
REQ-025 Invalid frame in any state: no push, set frame_error, rx_reset=1 next cycle, ->IDLE.
REQ-026 Timeout counter cleared on every frame_valid and in IDLE; on reaching TIMEOUT_CYCLES in a prefix state: ->IDLE, prefix discarded, rx_reset pulses one cycle, no error flag.
REQ-027 Push latency: event pushed on frame_valid cycle N is visible on ev_* / ev_valid in cycle N+1.
REQ-028 FIFO show-ahead: ev_code/ev_release/ev_extended reflect head whenever ev_valid=1; 0 when empty.
REQ-029 rd_en with ev_valid=1 pops head at that edge; rd_en with FIFO empty ignored.
REQ-030 Push when full without pop: event dropped, overflow set, contents unchanged.
REQ-031 Simultaneous push and pop (including when full): both performed, fifo_count unchanged, no overflow.
REQ-032 Pointers wrap modulo FIFO_DEPTH; events returned strictly in push order.
REQ-033 err_clear clears overflow and frame_error; a new error in the same cycle wins (flag stays 1).

Reset
REQ-034 rst=0 at a clk edge: state IDLE, FIFO empty, timeout counter 0, all outputs 0 (ev_valid, ev_*, fifo_count, fifo_full, overflow, frame_error, rx_reset).
REQ-035 frame_valid, rd_en, err_clear ignored while rst=0; reset mid-prefix or mid-FIFO discards all pending data.

Verification
REQ-036 frame=11'h438 (0x1C, parity 0) pulse -> next cycle ev_valid=1, code 0x1C, rel=0, ext=0, fifo_count=1.
REQ-037 frames F0 (11'h7E0), 0x1C -> exactly one event: code 0x1C, rel=1, ext=0; none after F0 alone.
REQ-038 frames E0, F0, 0x75 (11'h4EA) -> one event code 0x75, rel=1, ext=1; state back to IDLE.
REQ-039 0x1C with parity bit 1 (11'h638) -> no event, frame_error=1, rx_reset one-cycle pulse; err_clear -> frame_error=0.
REQ-040 FIFO_DEPTH+1 makes (0x01..0x05) without rd_en -> fifo_full=1, overflow=1; reads return 0x01..0x04 in order, then ev_valid=0.
REQ-041 E0 then TIMEOUT_CYCLES idle clocks -> rx_reset pulse; subsequent 0x1C -> ext=0, rel=0.

Source files
------------

// File: rtl/key_event_controller.sv
// PS/2 key event controller: decodes make/break/extended scan-code sequences
// from validated receiver frames and queues key events in a show-ahead FIFO.
module key_event_controller #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [10:0]                 frame,
    input  logic                        frame_valid,
    input  logic                        rd_en,
    input  logic                        err_clear,
    output logic                        ev_valid,
    output logic [7:0]                  ev_code,
    output logic                        ev_release,
    output logic                        ev_extended,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        fifo_full,
    output logic                        overflow,
    output logic                        frame_error,
    output logic                        rx_reset
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_F0 = 8'hF0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GOT_E0   = 2'd1,
        GOT_F0   = 2'd2,
        GOT_E0F0 = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               rx_reset_q, rx_reset_d;
    logic               overflow_q, frame_error_q;

    // Event FIFO storage: {extended, release, code}
    logic [9:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]     count_q, count_d;

    logic               frame_ok;
    logic [7:0]         data_byte;
    logic               push_req;
    logic [9:0]         push_word;
    logic               set_frame_err;
    logic               do_push, do_pop, set_overflow;
    logic               is_full;

    assign data_byte = frame[8:1];
    assign frame_ok  = ~frame[0] & frame[10] & (^frame[9:1]);

    // Decoder next-state: prefix tracking, event generation, error and timeout handling
    always_comb begin
        state_d       = state_q;
        tmo_d         = tmo_q;
        rx_reset_d    = 1'b0;
        push_req      = 1'b0;
        set_frame_err = 1'b0;
        push_word     = {(state_q == GOT_E0) || (state_q == GOT_E0F0),
                         (state_q == GOT_F0) || (state_q == GOT_E0F0),
                         data_byte};
        if (frame_valid) begin
            tmo_d = '0;
            if (!frame_ok) begin
                // Corrupt framing means the receiver likely lost bit alignment
                set_frame_err = 1'b1;
                rx_reset_d    = 1'b1;
                state_d       = IDLE;
            end else if (data_byte == 8'h00 || data_byte == 8'hFF) begin
                // Keyboard overrun/error codes: abandon any pending prefix
                set_frame_err = 1'b1;
                state_d       = IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (data_byte == BYTE_E0)      state_d = GOT_E0;
                        else if (data_byte == BYTE_F0) state_d = GOT_F0;
                        else                           push_req = 1'b1;
                    end
                    GOT_E0: begin
                        if (data_byte == BYTE_F0)      state_d = GOT_E0F0;
                        else if (data_byte != BYTE_E0) begin
                            push_req = 1'b1;
                            state_d  = IDLE;
                        end
                    end
                    GOT_F0: begin
                        if (data_byte == BYTE_E0)      state_d = GOT_E0F0;
                        else if (data_byte != BYTE_F0) begin
                            push_req = 1'b1;
                            state_d  = IDLE;
                        end
                    end
                    GOT_E0F0: begin
                        if (data_byte != BYTE_E0 && data_byte != BYTE_F0) begin
                            push_req = 1'b1;
                            state_d  = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end else if (state_q == IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            // Prefix went stale: drop it silently and resync the receiver
            tmo_d      = '0;
            state_d    = IDLE;
            rx_reset_d = 1'b1;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // Decoder state, timeout counter and resync pulse registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            tmo_q      <= '0;
            rx_reset_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            rx_reset_q <= rx_reset_d;
        end
    end

    // FIFO control: a pop frees a slot in the same edge, so push+pop on full succeeds
    assign is_full      = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
    assign do_pop       = rd_en && (count_q != '0);
    assign do_push      = push_req && (!is_full || do_pop);
    assign set_overflow = push_req && is_full && !do_pop;

    // Occupancy next-state
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // FIFO storage write; contents need no reset since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (rst && do_push) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    // Sticky error flags; a fresh error in the clearing cycle keeps the flag set
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            overflow_q    <= (overflow_q & ~err_clear) | set_overflow;
            frame_error_q <= (frame_error_q & ~err_clear) | set_frame_err;
        end
    end

    assign ev_valid    = (count_q != '0);
    assign ev_extended = ev_valid ? mem_q[rd_ptr_q][9] : 1'b0;
    assign ev_release  = ev_valid ? mem_q[rd_ptr_q][8] : 1'b0;
    assign ev_code     = ev_valid ? mem_q[rd_ptr_q][7:0] : 8'h00;
    assign fifo_count  = count_q;
    assign fifo_full   = is_full;
    assign overflow    = overflow_q;
    assign frame_error = frame_error_q;
    assign rx_reset    = rx_reset_q;

endmodule

// File: tb/tb_key_event_controller.sv
// Self-checking bench for key_event_controller: directed scenarios followed by
// randomized traffic compared cycle by cycle against a prefix-flag/queue model.
module tb_key_event_controller;

    localparam int DEPTH = 4;
    localparam int TMO   = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] frame = '0;
    logic        frame_valid = 1'b0;
    logic        rd_en = 1'b0;
    logic        err_clear = 1'b0;
    logic        ev_valid;
    logic [7:0]  ev_code;
    logic        ev_release;
    logic        ev_extended;
    logic [2:0]  fifo_count;
    logic        fifo_full;
    logic        overflow;
    logic        frame_error;
    logic        rx_reset;

    int checks = 0;
    int errors = 0;

    // Reference model: a pending prefix is just "E0 seen" / "F0 seen" flags
    bit [9:0] mq[$];
    bit       m_ext, m_rel;
    int       m_gap;
    bit       m_ovf, m_ferr, m_rxr;

    key_event_controller #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .frame(frame), .frame_valid(frame_valid),
        .rd_en(rd_en), .err_clear(err_clear), .ev_valid(ev_valid),
        .ev_code(ev_code), .ev_release(ev_release), .ev_extended(ev_extended),
        .fifo_count(fifo_count), .fifo_full(fifo_full), .overflow(overflow),
        .frame_error(frame_error), .rx_reset(rx_reset)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d);
        return {1'b1, ~^d, d, 1'b0};
    endfunction

    task automatic model_clear();
        mq.delete();
        m_ext = 0; m_rel = 0; m_gap = 0;
        m_ovf = 0; m_ferr = 0; m_rxr = 0;
    endtask

    // Apply one clock edge's worth of inputs to the model
    task automatic model_step(input bit fv, input bit [10:0] fr, input bit rd, input bit ec);
        bit       pop, push, new_err, new_ovf, ok;
        bit [7:0] d;
        bit [9:0] w;
        pop = rd && (mq.size() > 0);
        push = 0; new_err = 0; new_ovf = 0; w = '0;
        m_rxr = 0;
        if (fv) begin
            m_gap = 0;
            d  = fr[8:1];
            ok = (fr[0] == 1'b0) && (fr[10] == 1'b1) && ((^fr[9:1]) == 1'b1);
            if (!ok) begin
                new_err = 1; m_rxr = 1; m_ext = 0; m_rel = 0;
            end else if (d == 8'h00 || d == 8'hFF) begin
                new_err = 1; m_ext = 0; m_rel = 0;
            end else if (d == 8'hE0) begin
                m_ext = 1;
            end else if (d == 8'hF0) begin
                m_rel = 1;
            end else begin
                push = 1; w = {m_ext, m_rel, d}; m_ext = 0; m_rel = 0;
            end
        end else if (m_ext || m_rel) begin
            m_gap++;
            if (m_gap == TMO) begin
                m_ext = 0; m_rel = 0; m_gap = 0; m_rxr = 1;
            end
        end
        m_ferr = (m_ferr && !ec) || new_err;
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back(w);
            else new_ovf = 1;
        end
        m_ovf = (m_ovf && !ec) || new_ovf;
    endtask

    task automatic check_outputs(input string ctx);
        bit [9:0] head;
        head = (mq.size() > 0) ? mq[0] : 10'h0;
        check({ctx, ".ev_valid"},    ev_valid, mq.size() > 0);
        check({ctx, ".head"},        {ev_extended, ev_release, ev_code}, head);
        check({ctx, ".fifo_count"},  fifo_count, mq.size());
        check({ctx, ".fifo_full"},   fifo_full, mq.size() == DEPTH);
        check({ctx, ".overflow"},    overflow, m_ovf);
        check({ctx, ".frame_error"}, frame_error, m_ferr);
        check({ctx, ".rx_reset"},    rx_reset, m_rxr);
    endtask

    // One clock cycle of stimulus; outputs checked 1 time unit after the edge
    task automatic step(input string ctx, input bit fv, input bit [10:0] fr,
                        input bit rd, input bit ec);
        frame_valid = fv; frame = fr; rd_en = rd; err_clear = ec;
        @(posedge clk);
        model_step(fv, fr, rd, ec);
        #1;
        check_outputs(ctx);
        frame_valid = 0; rd_en = 0; err_clear = 0;
    endtask

    task automatic idle(input string ctx);
        step(ctx, 0, 11'h0, 0, 0);
    endtask

    // Reset with busy inputs, which must be ignored
    task automatic reset_dut();
        rst = 0;
        repeat (2) begin
            frame = mk(8'h1C); frame_valid = 1; rd_en = 1; err_clear = 1;
            @(posedge clk);
        end
        model_clear();
        #1;
        check_outputs("reset");
        frame_valid = 0; rd_en = 0; err_clear = 0;
        rst = 1;
    endtask

    initial begin
        int first_rx;
        model_clear();
        reset_dut();

        // Single make code
        $display("txn: make 0x1C");
        step("make", 1, 11'h438, 0, 0);
        check("make.valid", ev_valid, 1);
        check("make.code", ev_code, 8'h1C);
        check("make.relext", {ev_release, ev_extended}, 2'b00);
        check("make.count", fifo_count, 1);
        step("pop", 0, 11'h0, 1, 0);

        // Break code: F0 alone gives nothing
        $display("txn: break F0 1C");
        step("brk_f0", 1, 11'h7E0, 0, 0);
        check("brk_f0.none", ev_valid, 0);
        step("brk", 1, 11'h438, 0, 0);
        check("brk.code", ev_code, 8'h1C);
        check("brk.relext", {ev_release, ev_extended}, 2'b10);
        check("brk.count", fifo_count, 1);
        step("pop", 0, 11'h0, 1, 0);

        // Extended break
        $display("txn: ext break E0 F0 75");
        step("xb_e0", 1, mk(8'hE0), 0, 0);
        step("xb_f0", 1, mk(8'hF0), 0, 0);
        step("xb", 1, 11'h4EA, 0, 0);
        check("xb.code", ev_code, 8'h75);
        check("xb.relext", {ev_release, ev_extended}, 2'b11);
        step("pop", 0, 11'h0, 1, 0);
        step("xb_idle", 1, 11'h438, 0, 0);
        check("xb_idle.relext", {ev_release, ev_extended}, 2'b00);
        step("pop", 0, 11'h0, 1, 0);

        // Parity error
        $display("txn: bad parity 0x638");
        step("par", 1, 11'h638, 0, 0);
        check("par.valid", ev_valid, 0);
        check("par.ferr", frame_error, 1);
        check("par.rxr", rx_reset, 1);
        idle("par_idle");
        check("par.rxr_low", rx_reset, 0);
        step("par_clr", 0, 11'h0, 0, 1);
        check("par.cleared", frame_error, 0);

        // Overflow
        $display("txn: overflow 01..05");
        for (int i = 1; i <= DEPTH + 1; i++) step("ovf_push", 1, mk(8'(i)), 0, 0);
        check("ovf.full", fifo_full, 1);
        check("ovf.flag", overflow, 1);
        for (int i = 1; i <= DEPTH; i++) begin
            check("ovf.order", ev_code, i);
            step("ovf_pop", 0, 11'h0, 1, 0);
        end
        check("ovf.empty", ev_valid, 0);
        step("ovf_clr", 0, 11'h0, 0, 1);
        check("ovf.cleared", overflow, 0);

        // Push and pop together while full
        $display("txn: push+pop on full");
        for (int i = 0; i < DEPTH; i++) step("pp_fill", 1, mk(8'h10 + 8'(i)), 0, 0);
        step("pp", 1, mk(8'h2A), 1, 0);
        check("pp.count", fifo_count, DEPTH);
        check("pp.ovf", overflow, 0);
        check("pp.head", ev_code, 8'h11);
        for (int i = 0; i < DEPTH; i++) step("pp_drain", 0, 11'h0, 1, 0);
        check("pp.empty", ev_valid, 0);

        // Prefix timeout
        $display("txn: E0 timeout");
        step("tmo_e0", 1, mk(8'hE0), 0, 0);
        first_rx = -1;
        for (int n = 1; n <= TMO + 5; n++) begin
            idle("tmo_wait");
            if (rx_reset && first_rx < 0) first_rx = n;
        end
        check("tmo.cycles", first_rx, TMO);
        check("tmo.ferr", frame_error, 0);
        step("tmo_make", 1, 11'h438, 0, 0);
        check("tmo.relext", {ev_release, ev_extended}, 2'b00);
        check("tmo.code", ev_code, 8'h1C);

        // Randomized traffic
        $display("txn: random traffic");
        for (int c = 0; c < 3000; c++) begin
            int r;
            bit fv;
            bit [10:0] fr;
            bit [7:0] d;
            r = $urandom_range(0, 999);
            if (r < 5) begin
                reset_dut();
            end else if (r < 15) begin
                repeat (TMO + 3) idle("rnd_gap");
            end else begin
                fv = ($urandom_range(0, 99) < 35);
                r  = $urandom_range(0, 99);
                d  = 8'($urandom_range(1, 254));
                if (r < 20)      d = 8'hE0;
                else if (r < 35) d = 8'hF0;
                else if (r < 38) d = 8'h00;
                else if (r < 41) d = 8'hFF;
                fr = mk(d);
                r  = $urandom_range(0, 99);
                if (r < 3)      fr = fr ^ 11'h200;
                else if (r < 5) fr = fr ^ 11'h001;
                else if (r < 7) fr = fr ^ 11'h400;
                step("rnd", fv, fr, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
